// File: rtl/decode_rf_scoreboard.sv
// Decode-stage register file with write-back bypass, a late-result scoreboard,
// RAW/WAW interlock and an ID/EX pipeline register with valid/ready and flush.
module decode_rf_scoreboard #(
  parameter int DATA_W = 16,
  parameter int NREG   = 8,
  parameter int SEL_W  = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [SEL_W-1:0]  rd1_sel,
  input  logic [SEL_W-1:0]  rd2_sel,
  input  logic              rd1_used,
  input  logic              rd2_used,
  input  logic [SEL_W-1:0]  dst_sel,
  input  logic              dst_we,
  input  logic              dst_late,
  input  logic [DATA_W-1:0] imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_rd1,
  output logic [DATA_W-1:0] out_rd2,
  output logic [DATA_W-1:0] out_imm,
  output logic [SEL_W-1:0]  out_dst_sel,
  output logic              out_dst_we,
  output logic              out_dst_late,
  input  logic              wb_we,
  input  logic [SEL_W-1:0]  wb_sel,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              flush,
  output logic [NREG-1:0]   busy
);

  logic [DATA_W-1:0] rf_reg [NREG];
  logic [NREG-1:0]   busy_reg;
  logic [NREG-1:0]   busy_next;

  // Per-register decode of the write-back port and the late producer in ID/EX
  logic [NREG-1:0]   wb_hit;
  logic [NREG-1:0]   prod_hit;
  logic [NREG-1:0]   prod_set;
  logic [NREG-1:0]   pend;

  logic              prod_late;
  logic              raw1;
  logic              raw2;
  logic              waw;
  logic              hazard;
  logic              accept;
  logic [DATA_W-1:0] rd1;
  logic [DATA_W-1:0] rd2;

  assign prod_late = out_valid && out_dst_we && out_dst_late;

  genvar gi;
  generate
    for (gi = 0; gi < NREG; gi++) begin : g_reg
      assign wb_hit[gi]    = wb_we && (wb_sel == SEL_W'(gi));
      assign prod_hit[gi]  = prod_late && (out_dst_sel == SEL_W'(gi));
      // A flushed producer never reaches execute, so it must not mark busy
      assign prod_set[gi]  = prod_hit[gi] && out_ready && !flush;
      assign pend[gi]      = busy_reg[gi] || prod_hit[gi];
      assign busy_next[gi] = prod_set[gi] || (busy_reg[gi] && !wb_hit[gi]);
    end
  endgenerate

  assign rd1 = wb_hit[rd1_sel] ? wb_data : rf_reg[rd1_sel];
  assign rd2 = wb_hit[rd2_sel] ? wb_data : rf_reg[rd2_sel];

  // A same-cycle write-back satisfies a read, unless the producer still sits in ID/EX
  assign raw1 = rd1_used && pend[rd1_sel] && !(wb_hit[rd1_sel] && !prod_hit[rd1_sel]);
  assign raw2 = rd2_used && pend[rd2_sel] && !(wb_hit[rd2_sel] && !prod_hit[rd2_sel]);
  assign waw  = dst_we && dst_late && pend[dst_sel];

  assign hazard   = raw1 || raw2 || waw;
  assign in_ready = !flush && !hazard && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign busy     = busy_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREG; i++) begin
        rf_reg[i] <= '0;
      end
    end else if (wb_we) begin
      rf_reg[wb_sel] <= wb_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_reg <= '0;
    end else begin
      busy_reg <= busy_next;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid    <= 1'b0;
      out_rd1      <= '0;
      out_rd2      <= '0;
      out_imm      <= '0;
      out_dst_sel  <= '0;
      out_dst_we   <= 1'b0;
      out_dst_late <= 1'b0;
    end else if (accept) begin
      out_valid    <= 1'b1;
      out_rd1      <= rd1;
      out_rd2      <= rd2;
      out_imm      <= imm;
      out_dst_sel  <= dst_sel;
      out_dst_we   <= dst_we;
      out_dst_late <= dst_late;
    end else if (flush || out_ready) begin
      out_valid    <= 1'b0;
    end
  end

endmodule

// File: tb/tb_decode_rf_scoreboard.sv
// Directed testbench for decode_rf_scoreboard: register file, bypass,
// scoreboard interlocks, flush and asynchronous reset during a stall.
module tb_decode_rf_scoreboard;
  localparam int DATA_W = 16;
  localparam int NREG   = 8;
  localparam int SEL_W  = 3;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [SEL_W-1:0]  rd1_sel;
  logic [SEL_W-1:0]  rd2_sel;
  logic              rd1_used;
  logic              rd2_used;
  logic [SEL_W-1:0]  dst_sel;
  logic              dst_we;
  logic              dst_late;
  logic [DATA_W-1:0] imm;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_rd1;
  logic [DATA_W-1:0] out_rd2;
  logic [DATA_W-1:0] out_imm;
  logic [SEL_W-1:0]  out_dst_sel;
  logic              out_dst_we;
  logic              out_dst_late;
  logic              wb_we;
  logic [SEL_W-1:0]  wb_sel;
  logic [DATA_W-1:0] wb_data;
  logic              flush;
  logic [NREG-1:0]   busy;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  decode_rf_scoreboard #(.DATA_W(DATA_W), .NREG(NREG), .SEL_W(SEL_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .rd1_sel(rd1_sel), .rd2_sel(rd2_sel), .rd1_used(rd1_used), .rd2_used(rd2_used),
    .dst_sel(dst_sel), .dst_we(dst_we), .dst_late(dst_late), .imm(imm),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_rd1(out_rd1), .out_rd2(out_rd2), .out_imm(out_imm),
    .out_dst_sel(out_dst_sel), .out_dst_we(out_dst_we), .out_dst_late(out_dst_late),
    .wb_we(wb_we), .wb_sel(wb_sel), .wb_data(wb_data),
    .flush(flush), .busy(busy)
  );

  task automatic idle_inputs();
    in_valid = 0; rd1_sel = 0; rd2_sel = 0; rd1_used = 0; rd2_used = 0;
    dst_sel = 0; dst_we = 0; dst_late = 0; imm = 0;
    wb_we = 0; wb_sel = 0; wb_data = 0; flush = 0;
  endtask

  task automatic after_edge();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    out_ready = 1'b1;
    #2 rst = 1'b0;
    #1;
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    vectors++; if (busy !== 8'h00) begin miscompares++; $display("FAIL reset_busy: got %h want 00", busy); end
    vectors++; if (out_rd1 !== 16'h0000 || out_imm !== 16'h0000) begin miscompares++; $display("FAIL reset_out_data: got rd1=%h imm=%h want 0", out_rd1, out_imm); end
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    @(negedge clk); rst = 1'b1;
    $display("tx reset checked");
  endtask

  task automatic test_wb_read();
    @(negedge clk); idle_inputs(); wb_we = 1; wb_sel = 3; wb_data = 16'h1234;
    @(negedge clk); idle_inputs();
    in_valid = 1; rd1_sel = 3; rd1_used = 1; imm = 16'h0007; dst_sel = 1; dst_we = 1;
    #1;
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL wbread_in_ready: got %b want 1", in_ready); end
    after_edge();
    vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL wbread_out_valid: got %b want 1", out_valid); end
    vectors++; if (out_rd1 !== 16'h1234) begin miscompares++; $display("FAIL wbread_rd1: got %h want 1234", out_rd1); end
    vectors++; if (out_imm !== 16'h0007 || out_dst_sel !== 3'd1 || out_dst_we !== 1'b1) begin miscompares++; $display("FAIL wbread_fields: got imm=%h dst=%0d we=%b want 0007 1 1", out_imm, out_dst_sel, out_dst_we); end
    vectors++; if (busy !== 8'h00) begin miscompares++; $display("FAIL wbread_busy: got %h want 00", busy); end
    @(negedge clk); idle_inputs();
    after_edge();
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL wbread_drain: got %b want 0", out_valid); end
    $display("tx wb reg3=1234, read r3 -> %h", out_rd1);
  endtask

  task automatic test_bypass();
    @(negedge clk); idle_inputs();
    wb_we = 1; wb_sel = 5; wb_data = 16'hBEEF;
    in_valid = 1; rd1_sel = 5; rd1_used = 1; rd2_sel = 3; rd2_used = 1;
    after_edge();
    vectors++; if (out_rd1 !== 16'hBEEF) begin miscompares++; $display("FAIL bypass_rd1: got %h want beef", out_rd1); end
    vectors++; if (out_rd2 !== 16'h1234) begin miscompares++; $display("FAIL bypass_rd2: got %h want 1234", out_rd2); end
    @(negedge clk); idle_inputs();
    after_edge();
    $display("tx bypass r5 -> %h", 16'hBEEF);
  endtask

  task automatic test_raw_late();
    @(negedge clk); idle_inputs(); in_valid = 1; dst_sel = 2; dst_we = 1; dst_late = 1;
    after_edge();
    vectors++; if (out_valid !== 1'b1 || out_dst_late !== 1'b1 || out_dst_sel !== 3'd2) begin miscompares++; $display("FAIL raw_producer: got v=%b late=%b dst=%0d want 1 1 2", out_valid, out_dst_late, out_dst_sel); end
    @(negedge clk); idle_inputs(); in_valid = 1; rd1_sel = 2; rd1_used = 1;
    #1;
    vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL raw_vs_idex: got %b want 0", in_ready); end
    after_edge();
    vectors++; if (busy !== 8'h04) begin miscompares++; $display("FAIL raw_busy_set: got %h want 04", busy); end
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL raw_bubble: got %b want 0", out_valid); end
    @(negedge clk); #1;
    vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL raw_vs_busy: got %b want 0", in_ready); end
    @(negedge clk); wb_we = 1; wb_sel = 2; wb_data = 16'h0042;
    #1;
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL raw_wb_release: got %b want 1", in_ready); end
    after_edge();
    vectors++; if (out_rd1 !== 16'h0042 || out_valid !== 1'b1) begin miscompares++; $display("FAIL raw_rd1: got %h v=%b want 0042 1", out_rd1, out_valid); end
    vectors++; if (busy !== 8'h00) begin miscompares++; $display("FAIL raw_busy_clear: got %h want 00", busy); end
    @(negedge clk); idle_inputs();
    after_edge();
    $display("tx late r2 released by wb -> %h", out_rd1);
  endtask

  task automatic test_waw_held();
    @(negedge clk); idle_inputs(); out_ready = 0; in_valid = 1; dst_sel = 4; dst_we = 1; dst_late = 1;
    after_edge();
    vectors++; if (out_valid !== 1'b1 || out_dst_sel !== 3'd4) begin miscompares++; $display("FAIL waw_held_producer: got v=%b dst=%0d want 1 4", out_valid, out_dst_sel); end
    @(negedge clk); #1;
    vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL waw_stalled: got %b want 0", in_ready); end
    out_ready = 1; #1;
    vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL waw_vs_idex: got %b want 0", in_ready); end
    dst_late = 0; #1;
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL waw_nonlate_ok: got %b want 1", in_ready); end
    out_ready = 0; dst_late = 1;
    after_edge();
    vectors++; if (out_valid !== 1'b1 || busy !== 8'h00) begin miscompares++; $display("FAIL waw_hold: got v=%b busy=%h want 1 00", out_valid, busy); end
    $display("tx waw on r4 blocked");
  endtask

  task automatic test_flush();
    @(negedge clk); idle_inputs(); flush = 1; out_ready = 1; in_valid = 1; rd1_sel = 1; rd1_used = 1;
    #1;
    vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL flush_in_ready: got %b want 0", in_ready); end
    after_edge();
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL flush_out_valid: got %b want 0", out_valid); end
    vectors++; if (busy !== 8'h00) begin miscompares++; $display("FAIL flush_busy: got %h want 00", busy); end
    @(negedge clk); idle_inputs(); in_valid = 1; rd1_sel = 4; rd1_used = 1;
    #1;
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL flush_next_ready: got %b want 1", in_ready); end
    after_edge();
    vectors++; if (out_valid !== 1'b1 || out_rd1 !== 16'h0000) begin miscompares++; $display("FAIL flush_next: got v=%b rd1=%h want 1 0000", out_valid, out_rd1); end
    @(negedge clk); idle_inputs();
    after_edge();
    $display("tx flush of late r4 producer");
  endtask

  task automatic test_waw_busy_wb();
    @(negedge clk); idle_inputs(); in_valid = 1; dst_sel = 6; dst_we = 1; dst_late = 1;
    after_edge();
    @(negedge clk); idle_inputs();
    after_edge();
    vectors++; if (busy !== 8'h40) begin miscompares++; $display("FAIL wawwb_busy: got %h want 40", busy); end
    @(negedge clk); idle_inputs(); wb_we = 1; wb_sel = 6; wb_data = 16'h6666;
    in_valid = 1; dst_sel = 6; dst_we = 1; dst_late = 1;
    #1;
    vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL wawwb_not_waived: got %b want 0", in_ready); end
    dst_we = 0; dst_late = 0; rd1_sel = 6; rd1_used = 1;
    #1;
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL wawwb_raw_waived: got %b want 1", in_ready); end
    after_edge();
    vectors++; if (out_rd1 !== 16'h6666 || busy !== 8'h00) begin miscompares++; $display("FAIL wawwb_result: got rd1=%h busy=%h want 6666 00", out_rd1, busy); end
    @(negedge clk); idle_inputs();
    after_edge();
    $display("tx r6 wb with waw held, raw bypassed");
  endtask

  task automatic test_stall_reset();
    @(negedge clk); idle_inputs(); in_valid = 1; dst_sel = 1; dst_we = 1; dst_late = 1;
    after_edge();
    @(negedge clk); idle_inputs(); in_valid = 1; rd1_sel = 2; rd1_used = 1; imm = 16'h55AA; dst_sel = 7; dst_we = 1;
    after_edge();
    vectors++; if (busy !== 8'h02 || out_rd1 !== 16'h0042) begin miscompares++; $display("FAIL stall_setup: got busy=%h rd1=%h want 02 0042", busy, out_rd1); end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); idle_inputs(); out_ready = 0;
      in_valid = 1; rd1_sel = 5; rd1_used = 1; imm = 16'h1111; dst_sel = 3; dst_we = 1;
      #1;
      vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL stall_in_ready[%0d]: got %b want 0", c, in_ready); end
      after_edge();
      vectors++; if (out_valid !== 1'b1 || out_rd1 !== 16'h0042 || out_imm !== 16'h55AA || out_dst_sel !== 3'd7) begin
        miscompares++; $display("FAIL stall_hold[%0d]: got v=%b rd1=%h imm=%h dst=%0d want 1 0042 55aa 7", c, out_valid, out_rd1, out_imm, out_dst_sel);
      end
    end
    #1 rst = 1'b0;
    #1;
    vectors++; if (out_valid !== 1'b0 || busy !== 8'h00) begin miscompares++; $display("FAIL async_reset_ctrl: got v=%b busy=%h want 0 00", out_valid, busy); end
    vectors++; if (out_rd1 !== 16'h0000 || out_imm !== 16'h0000 || out_dst_sel !== 3'd0) begin miscompares++; $display("FAIL async_reset_data: got rd1=%h imm=%h dst=%0d want 0", out_rd1, out_imm, out_dst_sel); end
    @(negedge clk); rst = 1'b1; idle_inputs(); out_ready = 1;
    in_valid = 1; rd1_sel = 5; rd1_used = 1; rd2_sel = 2; rd2_used = 1;
    after_edge();
    vectors++; if (out_valid !== 1'b1 || out_rd1 !== 16'h0000 || out_rd2 !== 16'h0000) begin miscompares++; $display("FAIL async_reset_rf: got v=%b rd1=%h rd2=%h want 1 0000 0000", out_valid, out_rd1, out_rd2); end
    @(negedge clk); idle_inputs();
    after_edge();
    $display("tx stall then async reset");
  endtask

  initial begin
    test_reset();
    test_wb_read();
    test_bypass();
    test_raw_late();
    test_waw_held();
    test_flush();
    test_waw_busy_wb();
    test_stall_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/decode_rf_scoreboard.md
Name: decode_rf_scoreboard

Overview:
- Parametrised successor of the decode-stage register-file/bypass logic.
- Holds the architectural register file with write-back bypass, plus a scoreboard of registers with outstanding late (write-back-only, e.g. load) results.
- Interlocks RAW/WAW hazards against those producers and registers decoded operands into an ID/EX pipeline register with a valid/ready handshake and flush.
- Sits between instruction decode/control and execute.

Parameters:
DATA_W, 16, register and immediate width
NREG, 8, number of architectural registers
SEL_W, 3, register select width, equal to clog2(NREG)

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous, active-low reset
in_valid  input  1  decoded instruction present
in_ready  output  1  stage accepts instruction this cycle
rd1_sel  input  SEL_W  source register 1
rd2_sel  input  SEL_W  source register 2
rd1_used  input  1  source 1 is read by the instruction
rd2_used  input  1  source 2 is read by the instruction
dst_sel  input  SEL_W  destination register
dst_we  input  1  instruction writes dst_sel
dst_late  input  1  result available only at write-back
imm  input  DATA_W  sign-extended immediate
out_valid  output  1  ID/EX register holds an instruction
out_ready  input  1  execute consumes out_* this cycle
out_rd1  output  DATA_W  registered operand 1
out_rd2  output  DATA_W  registered operand 2
out_imm  output  DATA_W  registered immediate
out_dst_sel  output  SEL_W  registered destination
out_dst_we  output  1  registered write enable
out_dst_late  output  1  registered late flag
wb_we  input  1  write-back enable
wb_sel  input  SEL_W  write-back register
wb_data  input  DATA_W  write-back data
flush  input  1  squash ID/EX contents
busy  output  NREG  scoreboard bit per register

Behaviour:
- Reset (rst low, asynchronous): all registers 0, busy 0, out_valid 0, all out_* 0; deassertion is synchronised externally.
- Register file write: at posedge when wb_we, reg[wb_sel] <= wb_data.
- Read: combinational rdN = reg[rdN_sel], bypassed to wb_data when wb_we && wb_sel == rdN_sel.
- Scoreboard set: at the cycle out_valid && out_ready && out_dst_we && out_dst_late, busy[out_dst_sel] <= 1.
- Scoreboard clear: busy[wb_sel] <= 0 when wb_we.
- Set and clear of the same bit in one cycle: set wins.
- pend(r) = busy[r] || (out_valid && out_dst_we && out_dst_late && out_dst_sel == r).
- RAW hazard: rdN_used && pend(rdN_sel) && !(wb_we && wb_sel == rdN_sel && !(out_valid && out_dst_late && out_dst_we && out_dst_sel == rdN_sel)).
- WAW hazard: dst_we && dst_late && pend(dst_sel). A write-back in the same cycle does not waive WAW.
- in_ready = !flush && !hazard && (!out_valid || out_ready).
- Accept (in_valid && in_ready): capture bypassed operands, imm, dst_* into out_*; out_valid <= 1; latency 1 cycle.
- No accept and out_ready: out_valid <= 0; out_* hold their last value.
- No accept and !out_ready: all out_* held stable.
- flush: out_valid <= 0 next cycle; no accept that cycle; busy unaffected (older instructions still complete).
- Flush of a late producer held in ID/EX: busy is never set for it.
- Non-late producers are not tracked; execute-stage forwarding covers them.

Test Plan:
- Reset, write-back reg3=0x1234, then accept rd1_sel=3 -> out_rd1=0x1234 after 1 cycle, busy=0.
- Same-cycle write-back reg5=0xBEEF with accept reading reg5 -> out_rd1=0xBEEF (bypass).
- Accept late producer dst=2, consume with out_ready=1, then instruction reading r2 -> in_ready=0, busy[2]=1 until wb_we reg2=0x0042; that cycle in_ready=1 and out_rd1=0x0042.
- Late producer dst=4 held with out_ready=0, second late dst=4 -> in_ready=0 (WAW).
- Same late producer held, then flush -> out_valid=0, busy[4] stays 0, next instruction reading r4 accepted.
- out_ready=0 for 3 cycles with out_valid=1 -> out_* stable; assert rst low mid-stall -> out_valid=0, busy=0, registers 0 immediately.
